// File: rtl/exposure_timer_ctrl_pkg.sv
// Shared timing definitions for the camera exposure path: FSM encoding, widths,
// exposure range defaults and button auto-repeat delays.
package camera_timing_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EXP_CNT  = 2'b01,
        READ_CNT = 2'b10
    } state_t;

    localparam int EXP_W = 5;

    localparam int EXP_MIN_DEF  = 2;
    localparam int EXP_MAX_DEF  = 30;
    localparam int EXP_INIT_DEF = 15;

    localparam int REPEAT_DELAY_MS = 500;
    localparam int REPEAT_RATE_MS  = 100;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exposure_timer_ctrl_if.sv
// Button, start-pulse and status signals between the exposure-control FSM side
// and the exposure timer block.
interface exposure_timer_ctrl_if;
    import camera_timing_pkg::*;

    logic             Exp_increase;
    logic             Exp_decrease;
    logic             Timer_start;
    logic             Read_start;
    logic             Ovf5;
    logic             Ovf4;
    logic             Busy;
    logic [EXP_W-1:0] Exp_time;

    modport master (
        output Exp_increase, Exp_decrease, Timer_start, Read_start,
        input  Ovf5, Ovf4, Busy, Exp_time
    );

    modport slave (
        input  Exp_increase, Exp_decrease, Timer_start, Read_start,
        output Ovf5, Ovf4, Busy, Exp_time
    );

endinterface

// File: rtl/exposure_timer_ctrl_btn_edge_det.sv
// Rising-edge step generator for one exposure button; with EXP_AUTOREPEAT_EN
// defined it also issues repeat steps while the button stays held.
module btn_edge_det
    import camera_timing_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic btn,
`ifdef EXP_AUTOREPEAT_EN
    input  logic ms_tick,
    input  logic hold_en,
`endif
    output logic step
);

    logic level_q;
    logic level_d;
    logic edge_pulse;

    assign level_d    = btn;
    assign edge_pulse = btn & ~level_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

`ifdef EXP_AUTOREPEAT_EN
    localparam int HOLD_W = cnt_width(REPEAT_DELAY_MS);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              repeat_pulse;

    // After the first repeat the counter restarts part-way so later repeats
    // come every REPEAT_RATE_MS instead of REPEAT_DELAY_MS.
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        repeat_pulse = 1'b0;
        if (!(btn && hold_en)) begin
            hold_cnt_d = '0;
        end else if (ms_tick) begin
            if (hold_cnt_q == HOLD_W'(REPEAT_DELAY_MS - 1)) begin
                repeat_pulse = 1'b1;
                hold_cnt_d   = HOLD_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign step = edge_pulse | repeat_pulse;
`else
    assign step = edge_pulse;
`endif

endmodule

// File: rtl/exposure_timer_ctrl.sv
// Exposure-time setting plus exposure (Ovf5) and readout-step (Ovf4) timers.
// Optional button auto-repeat is enabled by defining EXP_AUTOREPEAT_EN.
module exposure_timer_ctrl
    import camera_timing_pkg::*;
#(
    parameter int CLK_PER_MS  = 1000,
    parameter int EXP_MIN     = EXP_MIN_DEF,
    parameter int EXP_MAX     = EXP_MAX_DEF,
    parameter int EXP_INIT    = EXP_INIT_DEF,
    parameter int READ_CYCLES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    exposure_timer_ctrl_if.slave  bus
);

    localparam int PS_W = cnt_width(CLK_PER_MS);
    localparam int RD_W = cnt_width(READ_CYCLES);

    state_t           state_q, state_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
    logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [EXP_W-1:0] exp_time_q, exp_time_d;
    logic             ovf5_q, ovf5_d;
    logic             ovf4_q, ovf4_d;

    logic             ms_tick;
    logic [1:0]       btn_lvl;
    logic [1:0]       btn_step;

    assign ms_tick = (presc_q == PS_W'(CLK_PER_MS - 1));
    assign btn_lvl = {bus.Exp_decrease, bus.Exp_increase};

`ifdef EXP_AUTOREPEAT_EN
    logic hold_en;
    assign hold_en = (state_q == IDLE) && !(&btn_lvl);
`endif

    // Index 0 is the increase button, index 1 the decrease button.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_edge_det u_det (
                .Clk     (Clk),
                .Reset   (Reset),
                .btn     (btn_lvl[gi]),
`ifdef EXP_AUTOREPEAT_EN
                .ms_tick (ms_tick),
                .hold_en (hold_en),
`endif
                .step    (btn_step[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        ovf5_d    = 1'b0;
        ovf4_d    = 1'b0;
        presc_d   = ms_tick ? '0 : presc_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.Timer_start) begin
                    state_d   = EXP_CNT;
                    exp_cnt_d = exp_time_q;
                    presc_d   = '0;
                end else if (bus.Read_start) begin
                    state_d  = READ_CNT;
                    rd_cnt_d = RD_W'(READ_CYCLES - 1);
                end
            end
            EXP_CNT: begin
                if (ms_tick) begin
                    if (exp_cnt_q == EXP_W'(1)) begin
                        ovf5_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        exp_cnt_d = exp_cnt_q - 1'b1;
                    end
                end
            end
            READ_CNT: begin
                if (rd_cnt_q == '0) begin
                    ovf4_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Setting changes only in IDLE; opposing steps in one cycle cancel.
    always_comb begin
        exp_time_d = exp_time_q;
        if (state_q == IDLE) begin
            if (btn_step[0] && !btn_step[1] && (exp_time_q < EXP_W'(EXP_MAX))) begin
                exp_time_d = exp_time_q + 1'b1;
            end else if (btn_step[1] && !btn_step[0] && (exp_time_q > EXP_W'(EXP_MIN))) begin
                exp_time_d = exp_time_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            exp_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            exp_time_q <= EXP_W'(EXP_INIT);
            ovf5_q     <= 1'b0;
            ovf4_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            exp_cnt_q  <= exp_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            exp_time_q <= exp_time_d;
            ovf5_q     <= ovf5_d;
            ovf4_q     <= ovf4_d;
        end
    end

    assign bus.Ovf5     = ovf5_q;
    assign bus.Ovf4     = ovf4_q;
    assign bus.Busy     = (state_q != IDLE);
    assign bus.Exp_time = exp_time_q;

endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// Directed self-checking bench for exposure_timer_ctrl with CLK_PER_MS=10;
// the auto-repeat scenario runs only when EXP_AUTOREPEAT_EN is defined.
module tb_exposure_timer_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    exposure_timer_ctrl_if bus ();

    exposure_timer_ctrl #(
        .CLK_PER_MS  (10),
        .EXP_MIN     (2),
        .EXP_MAX     (30),
        .EXP_INIT    (15),
        .READ_CYCLES (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic press(input logic inc, input logic dec);
        bus.Exp_increase = inc;
        bus.Exp_decrease = dec;
        tick(1);
        bus.Exp_increase = 1'b0;
        bus.Exp_decrease = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
    endtask

    // Pulses Timer_start and measures cycles from the sampling edge to Ovf5.
    task automatic run_exp(output int lat, output logic busy_gap,
                           output logic busy_at_ovf, output logic ovf_after);
        bus.Timer_start = 1'b1;
        tick(1);
        bus.Timer_start = 1'b0;
        busy_gap = !bus.Busy;
        lat = 0;
        while (lat < 400 && !bus.Ovf5) begin
            tick(1);
            lat++;
            if (!bus.Ovf5 && !bus.Busy) busy_gap = 1'b1;
        end
        busy_at_ovf = bus.Busy;
        tick(1);
        ovf_after = bus.Ovf5;
    endtask

    task automatic run_read(output int lat, output logic ovf_after);
        bus.Read_start = 1'b1;
        tick(1);
        bus.Read_start = 1'b0;
        lat = 0;
        while (lat < 100 && !bus.Ovf4) begin
            tick(1);
            lat++;
        end
        tick(1);
        ovf_after = bus.Ovf4;
    endtask

    task automatic test_reset();
        do_reset();
        $display("reset: Exp_time=%0d Busy=%0d", bus.Exp_time, bus.Busy);
        n_cmp++; if (bus.Exp_time !== 5'd15) begin n_err++; $display("FAIL reset_exp_time: got %0d want 15", bus.Exp_time); end
        n_cmp++; if (bus.Ovf5 !== 1'b0) begin n_err++; $display("FAIL reset_ovf5: got %b want 0", bus.Ovf5); end
        n_cmp++; if (bus.Ovf4 !== 1'b0) begin n_err++; $display("FAIL reset_ovf4: got %b want 0", bus.Ovf4); end
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    endtask

    task automatic test_exposure();
        int lat; logic gap, bz, after;
        tick(10);
        run_exp(lat, gap, bz, after);
        $display("exposure: latency=%0d", lat);
        n_cmp++; if (lat !== 150) begin n_err++; $display("FAIL exp_latency: got %0d want 150", lat); end
        n_cmp++; if (gap !== 1'b0) begin n_err++; $display("FAIL exp_busy_gap: got %b want 0", gap); end
        n_cmp++; if (bz !== 1'b0) begin n_err++; $display("FAIL exp_busy_at_ovf: got %b want 0", bz); end
        n_cmp++; if (after !== 1'b0) begin n_err++; $display("FAIL exp_ovf5_width: got %b want 0", after); end
    endtask

    task automatic test_buttons();
        int lat; logic gap, bz, after;
        for (int i = 0; i < 14; i++) press(1'b1, 1'b0);
        $display("buttons: after 14 inc Exp_time=%0d", bus.Exp_time);
        n_cmp++; if (bus.Exp_time !== 5'd29) begin n_err++; $display("FAIL inc_14: got %0d want 29", bus.Exp_time); end
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0);
        $display("buttons: after 20 inc Exp_time=%0d", bus.Exp_time);
        n_cmp++; if (bus.Exp_time !== 5'd30) begin n_err++; $display("FAIL inc_sat: got %0d want 30", bus.Exp_time); end
        for (int i = 0; i < 27; i++) press(1'b0, 1'b1);
        $display("buttons: after 27 dec Exp_time=%0d", bus.Exp_time);
        n_cmp++; if (bus.Exp_time !== 5'd3) begin n_err++; $display("FAIL dec_27: got %0d want 3", bus.Exp_time); end
        for (int i = 0; i < 13; i++) press(1'b0, 1'b1);
        $display("buttons: after 40 dec Exp_time=%0d", bus.Exp_time);
        n_cmp++; if (bus.Exp_time !== 5'd2) begin n_err++; $display("FAIL dec_sat: got %0d want 2", bus.Exp_time); end
        run_exp(lat, gap, bz, after);
        $display("buttons: exposure at 2 ms latency=%0d", lat);
        n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL exp_min_latency: got %0d want 20", lat); end
    endtask

    task automatic test_busy_freeze();
        int lat;
        bus.Timer_start = 1'b1;
        tick(1);
        bus.Timer_start = 1'b0;
        lat = 0;
        while (lat < 400 && !bus.Ovf5) begin
            tick(1);
            lat++;
            if (lat == 5) bus.Exp_increase = 1'b1;
        end
        $display("freeze: latency=%0d Exp_time=%0d", lat, bus.Exp_time);
        n_cmp++; if (lat !== 20) begin n_err++; $display("FAIL freeze_latency: got %0d want 20", lat); end
        n_cmp++; if (bus.Exp_time !== 5'd2) begin n_err++; $display("FAIL freeze_during: got %0d want 2", bus.Exp_time); end
        tick(3);
        bus.Exp_increase = 1'b0;
        tick(1);
        n_cmp++; if (bus.Exp_time !== 5'd2) begin n_err++; $display("FAIL freeze_held_after: got %0d want 2", bus.Exp_time); end
        press(1'b1, 1'b0);
        n_cmp++; if (bus.Exp_time !== 5'd3) begin n_err++; $display("FAIL inc_after_busy: got %0d want 3", bus.Exp_time); end
        press(1'b1, 1'b1);
        $display("freeze: both buttons Exp_time=%0d", bus.Exp_time);
        n_cmp++; if (bus.Exp_time !== 5'd3) begin n_err++; $display("FAIL both_buttons: got %0d want 3", bus.Exp_time); end
    endtask

    task automatic test_start_priority();
        int n5, n4;
        bus.Timer_start = 1'b1;
        bus.Read_start  = 1'b1;
        tick(1);
        bus.Timer_start = 1'b0;
        bus.Read_start  = 1'b0;
        n5 = 0; n4 = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            n5 += int'(bus.Ovf5);
            n4 += int'(bus.Ovf4);
        end
        $display("priority: ovf5=%0d ovf4=%0d", n5, n4);
        n_cmp++; if (n5 !== 1) begin n_err++; $display("FAIL prio_ovf5: got %0d want 1", n5); end
        n_cmp++; if (n4 !== 0) begin n_err++; $display("FAIL prio_ovf4: got %0d want 0", n4); end
    endtask

    task automatic test_read();
        int lat; logic after;
        int n5, n4;
        run_read(lat, after);
        $display("read: latency=%0d", lat);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL read_latency: got %0d want 4", lat); end
        n_cmp++; if (after !== 1'b0) begin n_err++; $display("FAIL read_ovf4_width: got %b want 0", after); end
        bus.Timer_start = 1'b1;
        tick(1);
        bus.Timer_start = 1'b0;
        n5 = 0; n4 = 0;
        for (int i = 0; i < 60; i++) begin
            bus.Read_start = (i == 3);
            tick(1);
            n5 += int'(bus.Ovf5);
            n4 += int'(bus.Ovf4);
        end
        bus.Read_start = 1'b0;
        $display("read during exposure: ovf5=%0d ovf4=%0d", n5, n4);
        n_cmp++; if (n5 !== 1) begin n_err++; $display("FAIL read_in_exp_ovf5: got %0d want 1", n5); end
        n_cmp++; if (n4 !== 0) begin n_err++; $display("FAIL read_in_exp_ovf4: got %0d want 0", n4); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.Read_start = 1'b1;
        tick(1);
        bus.Read_start = 1'b0;
        lat = 0;
        while (lat < 100 && !bus.Ovf4) begin tick(1); lat++; end
        bus.Read_start = 1'b1;
        tick(1);
        bus.Read_start = 1'b0;
        lat = 0;
        while (lat < 100 && !bus.Ovf4) begin tick(1); lat++; end
        $display("back_to_back: second read latency=%0d", lat);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL b2b_read_latency: got %0d want 4", lat); end
    endtask

    task automatic test_reset_mid();
        int n5, lat; logic gap, bz, after;
        do_reset();
        bus.Timer_start = 1'b1;
        tick(1);
        bus.Timer_start = 1'b0;
        tick(74);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        $display("reset_mid: Busy=%0d Exp_time=%0d", bus.Busy, bus.Exp_time);
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", bus.Busy); end
        n_cmp++; if (bus.Exp_time !== 5'd15) begin n_err++; $display("FAIL mid_reset_exp: got %0d want 15", bus.Exp_time); end
        n5 = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            n5 += int'(bus.Ovf5);
        end
        n_cmp++; if (n5 !== 0) begin n_err++; $display("FAIL mid_reset_ovf5: got %0d want 0", n5); end
        run_exp(lat, gap, bz, after);
        $display("reset_mid: new exposure latency=%0d", lat);
        n_cmp++; if (lat !== 150) begin n_err++; $display("FAIL mid_reset_relaunch: got %0d want 150", lat); end
    endtask

`ifdef EXP_AUTOREPEAT_EN
    task automatic test_autorepeat();
        do_reset();
        bus.Exp_increase = 1'b1;
        tick(8005);
        bus.Exp_increase = 1'b0;
        tick(2);
        $display("autorepeat: Exp_time=%0d", bus.Exp_time);
        n_cmp++; if (bus.Exp_time !== 5'd20) begin n_err++; $display("FAIL autorepeat: got %0d want 20", bus.Exp_time); end
    endtask
`endif

    initial begin
        bus.Exp_increase = 1'b0;
        bus.Exp_decrease = 1'b0;
        bus.Timer_start  = 1'b0;
        bus.Read_start   = 1'b0;
        test_reset();
        test_exposure();
        test_buttons();
        test_busy_freeze();
        test_start_priority();
        test_read();
        test_back_to_back();
        test_reset_mid();
`ifdef EXP_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
